alu_addsub_seq: RTL and testbench

- Parametrised, multi-cycle add/subtract unit for the 85-core ALU datapath.
- Processes a DATASIZE-bit operand pair SLICE bits per clock, LSB slice first.
- Carry/borrow ripples between slices through an internal register.
- Produces 8085-style flags (carry/borrow, aux-carry, zero, sign, parity) with a start/busy/done handshake, so wide or area-constrained builds can trade latency for adder width.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_addsub_seq_if.sv | 40 ++++
 rtl/addsub_slice.sv | 31 +++
 rtl/alu_addsub_seq.sv | 134 +++++++++++++
 tb/tb_alu_addsub_seq.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the sequential add/subtract unit.
// Build option: ALU_OVF_EN adds the two's-complement overflow flag oV.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Even parity over a zero-extended value; zero padding leaves parity unchanged.
    function automatic logic parity_even(input logic [63:0] x);
        return ~^x;
    endfunction

endpackage

// File: rtl/alu_addsub_seq_if.sv
// Request/response bundle for alu_addsub_seq.
// Build option: ALU_OVF_EN adds the overflow output oV.
interface alu_addsub_seq_if #(
    parameter int unsigned DATASIZE = 8
);
    logic                iStart;
    logic                iSub;
    logic                iUseC;
    logic                iC;
    logic [DATASIZE-1:0] iJ;
    logic [DATASIZE-1:0] iK;
    logic                oBusy;
    logic                oDone;
    logic [DATASIZE-1:0] oD;
    logic                oC;
    logic                oAC;
    logic                oZ;
    logic                oS;
    logic                oP;
`ifdef ALU_OVF_EN
    logic                oV;
`endif

    modport master (
        output iStart, iSub, iUseC, iC, iJ, iK,
        input  oBusy, oDone, oD, oC, oAC, oZ, oS, oP
`ifdef ALU_OVF_EN
        , input oV
`endif
    );

    modport slave (
        input  iStart, iSub, iUseC, iC, iJ, iK,
        output oBusy, oDone, oD, oC, oAC, oZ, oS, oP
`ifdef ALU_OVF_EN
        , output oV
`endif
    );

endinterface

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit ripple adder/subtractor; subtract inverts b.
// carry[0] is cin, carry[i+1] is the carry out of bit i.
module addsub_slice
    import alu_pkg::*;
#(
    parameter int unsigned SLICE = 2
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic [SLICE:0]   carry
);

    logic [SLICE-1:0] b_eff;

    always_comb begin
        b_eff    = (sub == OP_SUB) ? ~b : b;
        sum      = '0;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
            carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
        end
        cout = carry[SLICE];
    end

endmodule

// File: rtl/alu_addsub_seq.sv
// Multi-cycle add/subtract with 8085-style flags, SLICE bits per clock, LSB first.
// Build option: ALU_OVF_EN adds the registered overflow flag oV.
module alu_addsub_seq
    import alu_pkg::*;
#(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned SLICE    = 2
) (
    input logic             iCLK,
    input logic             iRSTn,
    alu_addsub_seq_if.slave bus
);

    localparam int unsigned NSLICE  = DATASIZE / SLICE;
    localparam int unsigned CntW    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned AcSlice = 3 / SLICE;
    localparam int unsigned AcBit   = 3 % SLICE;

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [DATASIZE-1:0] j_q, k_q, d_q;
    logic                sub_q, cy_q, ac_int_q;
    logic                busy_q, done_q, c_q, ac_q, z_q, s_q, p_q;
`ifdef ALU_OVF_EN
    logic                v_int_q, v_q;
`endif

    logic [SLICE-1:0]    sum;
    logic                cout;
    logic [SLICE:0]      carry;
    logic [DATASIZE-1:0] sum_ext;
    logic                cin_raw;
    logic                unused_carry;

    assign cin_raw      = bus.iUseC & bus.iC;
    assign sum_ext      = DATASIZE'(sum) << (DATASIZE - SLICE);
    assign unused_carry = ^carry;

    // Operands shift right each cycle so the adder always sees the current slice at bit 0.
    addsub_slice #(
        .SLICE(SLICE)
    ) u_slice (
        .a    (j_q[SLICE-1:0]),
        .b    (k_q[SLICE-1:0]),
        .cin  (cy_q),
        .sub  (sub_q),
        .sum  (sum),
        .cout (cout),
        .carry(carry)
    );

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            j_q      <= '0;
            k_q      <= '0;
            d_q      <= '0;
            sub_q    <= 1'b0;
            cy_q     <= 1'b0;
            ac_int_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            c_q      <= 1'b0;
            ac_q     <= 1'b0;
            z_q      <= 1'b0;
            s_q      <= 1'b0;
            p_q      <= 1'b0;
`ifdef ALU_OVF_EN
            v_int_q  <= 1'b0;
            v_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // The done pulse falls in IDLE; a start during it must be dropped.
                    if (bus.iStart && !done_q) begin
                        j_q     <= bus.iJ;
                        k_q     <= bus.iK;
                        sub_q   <= bus.iSub;
                        cy_q    <= (bus.iSub == OP_ADD) ? cin_raw : ~cin_raw;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    j_q   <= j_q >> SLICE;
                    k_q   <= k_q >> SLICE;
                    d_q   <= (d_q >> SLICE) | sum_ext;
                    cy_q  <= cout;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(AcSlice)) begin
                        ac_int_q <= carry[AcBit+1] ^ sub_q;
                    end
                    if (cnt_q == CntW'(NSLICE - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
`ifdef ALU_OVF_EN
                        v_int_q <= carry[SLICE] ^ carry[SLICE-1];
`endif
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    c_q     <= cy_q ^ sub_q;
                    ac_q    <= ac_int_q;
                    z_q     <= (d_q == '0);
                    s_q     <= d_q[DATASIZE-1];
                    p_q     <= parity_even(64'(d_q));
`ifdef ALU_OVF_EN
                    v_q     <= v_int_q;
`endif
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.oBusy = busy_q;
    assign bus.oDone = done_q;
    assign bus.oD    = d_q;
    assign bus.oC    = c_q;
    assign bus.oAC   = ac_q;
    assign bus.oZ    = z_q;
    assign bus.oS    = s_q;
    assign bus.oP    = p_q;
`ifdef ALU_OVF_EN
    assign bus.oV    = v_q;
`endif

endmodule

// File: tb/tb_alu_addsub_seq.sv
// Scoreboard bench for alu_addsub_seq in three shapes (8/2, 8/8, 16/4) driven in lockstep.
// Build option: ALU_OVF_EN also checks oV.
module tb_alu_addsub_seq;

    localparam int NCFG = 3;
    localparam int unsigned W_OF [NCFG] = '{8, 8, 16};
    localparam int unsigned S_OF [NCFG] = '{2, 8, 4};

    typedef struct {
        longint d;
        bit     c, ac, z, s, p, v;
        int     due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, op_sub, op_usec, op_c;
    logic [15:0] op_j, op_k;

    logic [NCFG-1:0] done_w, busy_w, c_w, ac_w, z_w, s_w, p_w, v_w;
    logic [15:0]     d_w [NCFG];

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb [NCFG][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int unsigned W = (g == 2) ? 16 : 8;
        localparam int unsigned S = (g == 0) ? 2 : ((g == 1) ? 8 : 4);

        alu_addsub_seq_if #(.DATASIZE(W)) ifc ();

        assign ifc.iStart = start;
        assign ifc.iSub   = op_sub;
        assign ifc.iUseC  = op_usec;
        assign ifc.iC     = op_c;
        assign ifc.iJ     = op_j[W-1:0];
        assign ifc.iK     = op_k[W-1:0];

        alu_addsub_seq #(
            .DATASIZE(W),
            .SLICE   (S)
        ) dut (
            .iCLK (clk),
            .iRSTn(rst_n),
            .bus  (ifc)
        );

        assign done_w[g] = ifc.oDone;
        assign busy_w[g] = ifc.oBusy;
        assign d_w[g]    = 16'(ifc.oD);
        assign c_w[g]    = ifc.oC;
        assign ac_w[g]   = ifc.oAC;
        assign z_w[g]    = ifc.oZ;
        assign s_w[g]    = ifc.oS;
        assign p_w[g]    = ifc.oP;
`ifdef ALU_OVF_EN
        assign v_w[g]    = ifc.oV;
`else
        assign v_w[g]    = 1'b0;
`endif
    end

    function automatic int lat(int g);
        return int'(W_OF[g] / S_OF[g]) + 1;
    endfunction

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(int w, bit sub, bit usec, bit cin, longint j, longint k);
        exp_t   e;
        longint m, hi, jj, kk, b, full, half, sj, sk, sr;
        m  = (longint'(1) << w) - 1;
        hi = longint'(1) << (w - 1);
        jj = j & m;
        kk = k & m;
        b  = (usec && cin) ? 1 : 0;
        sj = (jj >= hi) ? jj - (m + 1) : jj;
        sk = (kk >= hi) ? kk - (m + 1) : kk;
        if (!sub) begin
            full = jj + kk + b;
            e.c  = (full > m);
            half = (jj & 15) + (kk & 15) + b;
            e.ac = (half > 15);
            sr   = sj + sk + b;
        end else begin
            full = jj - kk - b;
            e.c  = (full < 0);
            half = (jj & 15) - (kk & 15) - b;
            e.ac = (half < 0);
            sr   = sj - sk - b;
        end
        e.d   = full & m;
        e.z   = (e.d == 0);
        e.s   = ((e.d >> (w - 1)) & 1) != 0;
        e.p   = ($countones(e.d) % 2) == 0;
        e.v   = (sr > hi - 1) || (sr < -hi);
        e.due = 0;
        return e;
    endfunction

    function automatic void chk(string name, int g, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cfg%0d: got %0h expected %0h (t=%0t)", name, g, act, exp, $time);
        end
    endfunction

    function automatic void push(int g);
        exp_t e;
        e     = model(int'(W_OF[g]), op_sub, op_usec, op_c, longint'(op_j), longint'(op_k));
        e.due = cyc + 1 + lat(g);
        sb[g].push_back(e);
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int g = 0; g < NCFG; g++) begin
                    if (done_w[g]) begin
                        if (sb[g].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_done cfg%0d: got oDone=1 oD=%0h expected no done",
                                     g, d_w[g]);
                        end else begin
                            e = sb[g].pop_front();
                            chk("latency", g, longint'(cyc), longint'(e.due));
                            chk("oD", g, longint'(d_w[g]), e.d);
                            chk("oC", g, longint'(c_w[g]), longint'(e.c));
                            chk("oAC", g, longint'(ac_w[g]), longint'(e.ac));
                            chk("oZ", g, longint'(z_w[g]), longint'(e.z));
                            chk("oS", g, longint'(s_w[g]), longint'(e.s));
                            chk("oP", g, longint'(p_w[g]), longint'(e.p));
`ifdef ALU_OVF_EN
                            chk("oV", g, longint'(v_w[g]), longint'(e.v));
`endif
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_zero(string name);
        for (int g = 0; g < NCFG; g++) begin
            chk(name, g, longint'({busy_w[g], done_w[g], c_w[g], ac_w[g], z_w[g], s_w[g],
                                   p_w[g], v_w[g], d_w[g]}), 0);
        end
    endtask

    // Start accepted by every shape; operands are scrambled afterwards to test latching.
    task automatic issue(bit sub, bit usec, bit cin, logic [15:0] j, logic [15:0] k);
        @(negedge clk);
        op_sub  = sub;
        op_usec = usec;
        op_c    = cin;
        op_j    = j;
        op_k    = k;
        start   = 1'b1;
        for (int g = 0; g < NCFG; g++) push(g);
        @(negedge clk);
        start   = 1'b0;
        op_j    = 16'($urandom);
        op_k    = 16'($urandom);
        op_sub  = 1'($urandom);
        op_c    = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if ((sb[0].size() + sb[1].size() + sb[2].size()) != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d results outstanding expected 0",
                     sb[0].size() + sb[1].size() + sb[2].size());
            for (int g = 0; g < NCFG; g++) sb[g].delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        op_sub  = 1'b0;
        op_usec = 1'b0;
        op_c    = 1'b0;
        op_j    = '0;
        op_k    = '0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        issue(1'b1, 1'b0, 1'b0, 16'h003A, 16'h000F);
        wait_idle();
        issue(1'b1, 1'b0, 1'b0, 16'h0005, 16'h0007);
        wait_idle();
        issue(1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0001);
        wait_idle();
        issue(1'b0, 1'b1, 1'b1, 16'h007F, 16'h0000);
        wait_idle();
        issue(1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
        wait_idle();

        // Extra starts in cycles 2 and 5; a shape takes one only once its done cycle is past.
        issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0020);
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            start = (t == 2 || t == 5);
            if (start) begin
                op_sub  = 1'($urandom);
                op_usec = 1'($urandom);
                op_c    = 1'($urandom);
                op_j    = 16'($urandom);
                op_k    = 16'($urandom);
                for (int g = 0; g < NCFG; g++) begin
                    if (t > lat(g)) push(g);
                end
            end
        end
        start = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of an operation.
        issue(1'b0, 1'b0, 1'b0, 16'h1234, 16'h4321);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        for (int g = 0; g < NCFG; g++) sb[g].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 1'b1, 1'b1, 16'h0041, 16'h0022);
        wait_idle();

        for (int n = 0; n < 30; n++) begin
            issue(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
